// File: rtl/rice_pkg.sv
// Shared types and constants for the Rice stream decoder.
// The ESC state is only reachable when RICE_ESCAPE_EN is defined.
package rice_pkg;

  typedef enum logic [1:0] {
    ST_UNARY,
    ST_REM,
    ST_ESC,
    ST_OUT
  } rice_state_e;

  localparam logic ERR_NONE     = 1'b0;
  localparam logic ERR_OVERFLOW = 1'b1;

  localparam int RICE_DEF_DATA_W = 16;
  localparam int RICE_DEF_K_MAX  = 8;
  localparam int RICE_DEF_Q_MAX  = 31;

  // Bits needed for a counter that must hold the value maxVal itself.
  function automatic int rice_cnt_w(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/rice_shift_acc.sv
// MSB-first shift accumulator with a loadable bit count.
// Used for the remainder field and, with RICE_ESCAPE_EN, the escape literal.
module rice_shift_acc
  import rice_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LEN_MAX = 16,
  parameter int LEN_W   = rice_cnt_w(LEN_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  logic [DATA_W-1:0] r_data;
  logic [LEN_W-1:0]  r_left;

  // A load clears the field so a short remainder never picks up stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_data <= '0;
      r_left <= i_len;
    end else if (i_shift && (r_left != '0)) begin
      r_data <= {r_data[DATA_W-2:0], i_bit};
      r_left <= r_left - LEN_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_last = (r_left == LEN_W'(1));

endmodule

// File: rtl/rice_stream_decoder.sv
// Bit-serial Rice decoder: unary quotient, k-bit remainder, valid/ready on both sides.
// Define RICE_ESCAPE_EN to read a DATA_W-bit raw literal after a quotient overflow.
module rice_stream_decoder
  import rice_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K_MAX  = 8,
  parameter int Q_MAX  = 31,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_bit,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(K_MAX+1)-1:0]   k_in,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_err,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             sym_cnt
);

  localparam int KW = rice_cnt_w(K_MAX);
  localparam int QW = rice_cnt_w(Q_MAX);
`ifdef RICE_ESCAPE_EN
  localparam int ACC_LEN_MAX = (DATA_W > K_MAX) ? DATA_W : K_MAX;
`else
  localparam int ACC_LEN_MAX = K_MAX;
`endif
  localparam int ACC_LW = rice_cnt_w(ACC_LEN_MAX);
  localparam logic [KW-1:0] K_LIMIT = KW'(K_MAX);
  localparam logic [QW-1:0] Q_LIMIT = QW'(Q_MAX);

  rice_state_e       r_state;
  logic [QW-1:0]     r_q;
  logic [KW-1:0]     r_k;
  logic              r_started;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_err;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_sym_cnt;

  logic              w_accept;
  logic [KW-1:0]     w_k_clamped;
  logic [KW-1:0]     w_k_sym;
  logic [QW-1:0]     w_q_inc;
  logic              w_q_full;
  logic              w_acc_load;
  logic [ACC_LW-1:0] w_acc_len;
  logic              w_acc_shift;
  logic [DATA_W-1:0] w_acc_data;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_acc_last;

  assign in_ready    = (r_state != ST_OUT);
  assign w_accept    = in_valid && in_ready;
  assign w_k_clamped = (k_in > K_LIMIT) ? K_LIMIT : k_in;
  // k is only taken from k_in on the first bit; later bits use the latched copy.
  assign w_k_sym     = r_started ? r_k : w_k_clamped;
  assign w_q_inc     = r_q + QW'(1);
  assign w_q_full    = in_bit && (w_q_inc == Q_LIMIT);
  assign w_acc_shift = w_accept && ((r_state == ST_REM) || (r_state == ST_ESC));
  assign w_acc_next  = {w_acc_data[DATA_W-2:0], in_bit};

`ifdef RICE_ESCAPE_EN
  assign w_acc_load = w_accept && (r_state == ST_UNARY) &&
                      ((!in_bit && (w_k_sym != '0)) || w_q_full);
  assign w_acc_len  = in_bit ? ACC_LW'(DATA_W) : ACC_LW'(w_k_sym);
`else
  assign w_acc_load = w_accept && (r_state == ST_UNARY) && !in_bit && (w_k_sym != '0);
  assign w_acc_len  = ACC_LW'(w_k_sym);
`endif

  rice_shift_acc #(
    .DATA_W  (DATA_W),
    .LEN_MAX (ACC_LEN_MAX),
    .LEN_W   (ACC_LW)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_acc_load),
    .i_len   (w_acc_len),
    .i_shift (w_acc_shift),
    .i_bit   (in_bit),
    .o_data  (w_acc_data),
    .o_last  (w_acc_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_UNARY;
      r_q         <= '0;
      r_k         <= '0;
      r_started   <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= ERR_NONE;
      r_out_valid <= 1'b0;
      r_sym_cnt   <= '0;
    end else begin
      case (r_state)
        ST_UNARY: begin
          if (w_accept) begin
            if (!r_started) begin
              r_started <= 1'b1;
              r_k       <= w_k_clamped;
            end
            if (w_q_full) begin
`ifdef RICE_ESCAPE_EN
              r_q     <= w_q_inc;
              r_state <= ST_ESC;
`else
              // Overflow ends the symbol; the next bit is the resync point.
              r_out_data  <= '0;
              r_out_err   <= ERR_OVERFLOW;
              r_out_valid <= 1'b1;
              r_state     <= ST_OUT;
`endif
            end else if (in_bit) begin
              r_q <= w_q_inc;
            end else if (w_k_sym != '0) begin
              r_state <= ST_REM;
            end else begin
              r_out_data  <= DATA_W'(r_q);
              r_out_err   <= ERR_NONE;
              r_out_valid <= 1'b1;
              r_state     <= ST_OUT;
            end
          end
        end
        ST_REM: begin
          if (w_accept && w_acc_last) begin
            r_out_data  <= (DATA_W'(r_q) << r_k) | w_acc_next;
            r_out_err   <= ERR_NONE;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
`ifdef RICE_ESCAPE_EN
        ST_ESC: begin
          if (w_accept && w_acc_last) begin
            r_out_data  <= w_acc_next;
            r_out_err   <= ERR_NONE;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
`endif
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_sym_cnt   <= r_sym_cnt + CNT_W'(1);
            r_q         <= '0;
            r_started   <= 1'b0;
            r_state     <= ST_UNARY;
          end
        end
        default: r_state <= ST_UNARY;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;
  assign sym_cnt   = r_sym_cnt;

endmodule

// File: tb/tb_rice_stream_decoder.sv
// Scoreboard bench for rice_stream_decoder; expectations follow RICE_ESCAPE_EN.
module tb_rice_stream_decoder;

  localparam int DATA_W = 16;
  localparam int K_MAX  = 8;
  localparam int Q_MAX  = 31;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } expT;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              inBit;
  logic              inValid;
  logic              inReady;
  logic [3:0]        kIn;
  logic [DATA_W-1:0] outData;
  logic              outErr;
  logic              outValid;
  logic              outReady;
  logic [CNT_W-1:0]  symCnt;

  expT              expQ[$];
  expT              monExp;
  logic [CNT_W-1:0] expCnt;
  int               nChecks = 0;
  int               nPass   = 0;

  rice_stream_decoder #(
    .DATA_W (DATA_W),
    .K_MAX  (K_MAX),
    .Q_MAX  (Q_MAX),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (inBit),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .k_in      (kIn),
    .out_data  (outData),
    .out_err   (outErr),
    .out_valid (outValid),
    .out_ready (outReady),
    .sym_cnt   (symCnt)
  );

  always #5 clk = ~clk;

  // Output handshakes are sampled mid-cycle and checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      nChecks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_output got data=%h err=%b want none", outData, outErr);
      end else begin
        monExp = expQ.pop_front();
        if (outData !== monExp.data || outErr !== monExp.err)
          $display("[TB] FAIL scoreboard got data=%h err=%b want data=%h err=%b",
                   outData, outErr, monExp.data, monExp.err);
        else
          nPass++;
      end
    end
  end

  task automatic pushExp(input logic [DATA_W-1:0] d, input logic e);
    expT x;
    x.data = d;
    x.err  = e;
    expQ.push_back(x);
    expCnt = expCnt + CNT_W'(1);
  endtask

  // Drives one bit and returns once it is accepted; waited counts stalled edges.
  task automatic applyStimulus(input logic b, input logic [3:0] k, output int waited);
    waited  = 0;
    inBit   = b;
    kIn     = k;
    inValid = 1'b1;
    while (inReady !== 1'b1 && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    if (inReady !== 1'b1) begin
      nChecks++;
      $display("[TB] FAIL in_ready_timeout got in_ready=%b want 1", inReady);
    end
    @(posedge clk); #1;
  endtask

  task automatic checkValidNow(input string name);
    nChecks++;
    if (outValid !== 1'b1) $display("[TB] FAIL %s got out_valid=%b want 1", name, outValid);
    else nPass++;
  endtask

  task automatic drain(input string name);
    int n = 0;
    inValid = 1'b0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    nChecks++;
    if (expQ.size() != 0) $display("[TB] FAIL %s_drain got pending=%0d want 0", name, expQ.size());
    else nPass++;
    nChecks++;
    if (symCnt !== expCnt) $display("[TB] FAIL %s_sym_cnt got %0d want %0d", name, symCnt, expCnt);
    else nPass++;
  endtask

  // Sends q ones, a 0, then k remainder bits; k_in is scrambled after the first bit.
  task automatic sendSymbol(input int q, input int k, input int r, input string name);
    int w;
    logic [DATA_W-1:0] v;
    v = DATA_W'((q << k) | r);
    pushExp(v, 1'b0);
    for (int i = 0; i < q; i++) applyStimulus(1'b1, (i == 0) ? 4'(k) : 4'($urandom_range(0, 15)), w);
    applyStimulus(1'b0, (q == 0) ? 4'(k) : 4'($urandom_range(0, 15)), w);
    for (int i = k - 1; i >= 0; i--) applyStimulus(1'(r >> i), 4'($urandom_range(0, 15)), w);
    checkValidNow(name);
  endtask

  task automatic checkResetState(input string name);
    nChecks++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || outData !== '0 || outErr !== 1'b0 || symCnt !== '0)
      $display("[TB] FAIL %s got valid=%b ready=%b data=%h err=%b cnt=%0d want 0 1 0 0 0",
               name, outValid, inReady, outData, outErr, symCnt);
    else
      nPass++;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inBit    = 1'b0;
    kIn      = '0;
    outReady = 1'b1;
    expCnt   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset_values");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int w;
    logic [4:0] bits = 5'b11010;
    pushExp(16'd10, 1'b0);
    for (int i = 4; i >= 0; i--) applyStimulus(bits[i], 4'd2, w);
    checkValidNow("basic_latency");
    drain("basic");
  endtask

  task automatic test_k0_bubble();
    int w;
    pushExp(16'd0, 1'b0);
    pushExp(16'd1, 1'b0);
    applyStimulus(1'b0, 4'd0, w);
    checkValidNow("k0_first");
    applyStimulus(1'b1, 4'd0, w);
    nChecks++;
    if (w != 1) $display("[TB] FAIL k0_bubble got %0d want 1", w);
    else nPass++;
    applyStimulus(1'b0, 4'd0, w);
    checkValidNow("k0_second");
    drain("k0");
  endtask

  task automatic test_stall();
    int w;
    logic [3:0] bits = 4'b0111;
    outReady = 1'b0;
    pushExp(16'd7, 1'b0);
    for (int i = 3; i >= 0; i--) applyStimulus(bits[i], 4'd3, w);
    inValid = 1'b1;
    inBit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (outValid !== 1'b1 || outData !== 16'd7 || inReady !== 1'b0)
        $display("[TB] FAIL stall_hold got valid=%b data=%h ready=%b want 1 0007 0",
                 outValid, outData, inReady);
      else
        nPass++;
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    drain("stall");
  endtask

  task automatic test_escape();
    int w;
    logic [DATA_W-1:0] lit = 16'hBEEF;
`ifdef RICE_ESCAPE_EN
    pushExp(lit, 1'b0);
    for (int i = 0; i < Q_MAX; i++) applyStimulus(1'b1, 4'd0, w);
    for (int i = DATA_W - 1; i >= 0; i--) applyStimulus(lit[i], 4'd0, w);
    checkValidNow("escape_literal");
`else
    pushExp('0, 1'b1);
    for (int i = 0; i < Q_MAX; i++) applyStimulus(1'b1, 4'd0, w);
    checkValidNow("escape_overflow");
    nChecks++;
    if (lit == 16'hBEEF && outErr !== 1'b1) $display("[TB] FAIL overflow_err got %b want 1", outErr);
    else nPass++;
`endif
    drain("escape");
  endtask

  task automatic test_reset_mid();
    int w;
    logic [5:0] bits = 6'b100001;
    applyStimulus(1'b1, 4'd4, w);
    applyStimulus(1'b1, 4'd4, w);
    inValid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkResetState("reset_mid");
    expQ.delete();
    expCnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pushExp(16'd17, 1'b0);
    for (int i = 5; i >= 0; i--) applyStimulus(bits[i], 4'd4, w);
    checkValidNow("reset_resume");
    drain("reset_mid");
  endtask

  task automatic test_clamp();
    int w;
    pushExp(16'd255, 1'b0);
    applyStimulus(1'b0, 4'd12, w);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'd12, w);
    checkValidNow("clamp_k");
    drain("clamp");
  endtask

  task automatic test_back_to_back();
    int q, k, r;
    for (int s = 0; s < 8; s++) begin
      q = $urandom_range(0, 6);
      k = $urandom_range(0, K_MAX);
      r = (k == 0) ? 0 : $urandom_range(0, (1 << k) - 1);
      sendSymbol(q, k, r, "b2b_latency");
    end
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_k0_bubble();
    test_stall();
    test_escape();
    test_reset_mid();
    test_clamp();
    test_back_to_back();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rice_stream_decoder.md
# rice_stream_decoder

Parametrised, bit-serial Rice (Golomb power-of-two) decoder for the Rice coding path. It consumes a compressed bitstream one bit per accepted cycle with a valid/ready handshake. Each symbol is a unary quotient followed by a k-bit remainder, with k selectable per symbol; the block emits the reconstructed value on a valid/ready output port. It replaces the fixed single-shot byte decoder with a streaming, back-pressurable, width- and depth-configurable block placed between the bitstream unpacker and the sample sink.

## Interface
- DATA_W, 16: width of decoded value and of escape literal
- K_MAX, 8: largest supported remainder length; `k_in` width is $clog2(K_MAX+1)
- Q_MAX, 31: largest legal quotient; quotient counter width is $clog2(Q_MAX+1)
- CNT_W, 16: width of symbol counter

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_bit  in  1  stream bit
- in_valid  in  1  in_bit is valid
- in_ready  out  1  block accepts in_bit this cycle
- k_in  in  $clog2(K_MAX+1)  remainder length, sampled on the first accepted bit of a symbol
- out_data  out  DATA_W  decoded value
- out_err  out  1  symbol quotient overflow (qualified by out_valid)
- out_valid  out  1  out_data/out_err valid
- out_ready  in  1  sink accepts output
- sym_cnt  out  CNT_W  count of symbols delivered, wraps modulo 2^CNT_W

## Operation
- Bit accepted when in_valid && in_ready.
- Bit order: unary run of 1s, terminated by a single 0; then k remainder bits, MSB first.
- States: UNARY, REM, ESC (macro only), OUT.
- UNARY:
  - First accepted bit of a symbol latches k_k = min(k_in, K_MAX).
  - Each 1 increments q.
  - A 0 goes to REM if k_k > 0; otherwise it goes to OUT with r = 0.
  - q reaching Q_MAX on an accepted 1 triggers overflow handling (see Configuration).
- REM: shifts bits into r, MSB first; after k_k bits, goes to OUT.
- OUT:
  - out_data = ((q << k_k) | r) truncated to DATA_W.
  - out_valid is held high, with data stable, until out_ready.
  - On handshake: sym_cnt increments, q, r and count clear, state returns to UNARY.
- in_ready = 1 in UNARY/REM/ESC, 0 in OUT.
- Reset values: out_data 0, out_err 0, out_valid 0, in_ready 1 (state UNARY), sym_cnt 0.
- Reset mid-symbol discards the partial symbol. No output is produced for it.
- k_in changes mid-symbol are ignored until the next symbol.

## Timing
- out_valid rises the cycle after the final bit of a symbol is accepted: the terminator 0 when k = 0, otherwise the last remainder bit.
- Throughput: one bit per cycle. Symbol cost is (q + 1 + k) input cycles plus at least 1 OUT cycle.
- Output handshake in OUT returns to UNARY on the next edge. No bit is accepted in the OUT cycle, so back-to-back symbols have a 1-cycle input bubble.
- out_ready held low stalls the input indefinitely. No data is lost.
- in_valid low in any state holds all state.

## Configuration
- RICE_ESCAPE_EN defined:
  - q reaching Q_MAX enters ESC, which reads DATA_W raw bits MSB first.
  - OUT then presents the literal with out_err = 0. No terminator 0 is consumed.
- RICE_ESCAPE_EN undefined:
  - q reaching Q_MAX goes directly to OUT with out_data = 0 and out_err = 1.
  - The next accepted bit starts a fresh symbol, which is the resync point.
  - ESC state and its bit counter are not built.

## Structure
- Package rice_pkg holds:
  - the state enum typedef (UNARY, REM, ESC, OUT);
  - width helper localparams;
  - the out_err code constant.
- One sub-module, rice_shift_acc: an MSB-first shift register with load-count and done flag, DATA_W wide. It is shared by REM and ESC.
- The top module holds the FSM, q counter, k latch, output register and sym_cnt.

## Test plan
- k_in = 2, bits 1,1,0,1,0 with out_ready = 1 → out_data = 10, out_err = 0, sym_cnt = 1.
- k_in = 0, bits 0 then 1,0 → two outputs, 0 and 1. in_ready is low exactly one cycle between them.
- k_in = 3, bits 0,1,1,1, with out_ready held low for 5 cycles → out_data = 7 stays stable, in_ready stays 0, and the output is delivered on release.
- Escape with DATA_W = 16, Q_MAX = 31: 31 ones then 0xBEEF MSB first → with the macro, out_data = 0xBEEF, out_err = 0. Without the macro, out_err = 1 after the 31st one.
- rst_n asserted after bits 1,1 of a k = 4 symbol → outputs return to reset values. Next stream 1,0,0,0,0,1 (k = 4) → out_data = 17.
- k_in = 12 with K_MAX = 8 → k is clamped to 8: bits 0 then 8×1 → out_data = 255.
